// File: rtl/sram_bridge_if.sv
// sram_bridge_if: control/status bundle between the AVR port logic and the
// SRAM bridge. The tri-state data buses stay plain inout ports on the bridge.
//   avr_si, avr_sreg_en, avr_ctrl, avr_oe, avr_we : AVR side controls
//   sram_addr, sram_oe_n, sram_we_n, sram_ce_n     : SRAM side controls
//   busy                                           : access in progress
interface sram_bridge_if #(
    parameter int ADDR_W = 21
) ();
    logic              avr_si;
    logic              avr_sreg_en;
    logic [1:0]        avr_ctrl;
    logic              avr_oe;
    logic              avr_we;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ce_n;
    logic              busy;

    modport slave (
        input  avr_si, avr_sreg_en, avr_ctrl, avr_oe, avr_we,
        output sram_addr, sram_oe_n, sram_we_n, sram_ce_n, busy
    );

    modport master (
        output avr_si, avr_sreg_en, avr_ctrl, avr_oe, avr_we,
        input  sram_addr, sram_oe_n, sram_we_n, sram_ce_n, busy
    );
endinterface

// File: rtl/sram_bridge.sv
// sram_bridge: serial address loader plus AVR-strobe to SRAM-cycle sequencer.
// The address is shifted in MSB first while avr_sreg_en=0; on entering bus
// mode it is copied to sram_addr. Falling AVR strobes in bus mode start a
// timed SRAM read or write; on completion the address may post-increment or
// post-decrement for burst transfers.
// Ports:
//   avr_clk   : clock, rising edge
//   avr_reset : asynchronous active-low reset
//   bus       : sram_bridge_if.slave control/status bundle
//   avr_data  : AVR data bus (driven only while presenting read data)
//   sram_data : SRAM data bus (driven only during the write data window)
module sram_bridge #(
    parameter int ADDR_W    = 21,
    parameter int DATA_W    = 8,
    parameter int RD_CYCLES = 1,
    parameter int WE_CYCLES = 2
) (
    input  logic              avr_clk,
    input  logic              avr_reset,
    sram_bridge_if.slave      bus,
    inout  wire  [DATA_W-1:0] avr_data,
    inout  wire  [DATA_W-1:0] sram_data
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_SETUP = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] RD_HOLD  = 3'd3;
    localparam logic [2:0] WR_SETUP = 3'd4;
    localparam logic [2:0] WR_PULSE = 3'd5;
    localparam logic [2:0] WR_DONE  = 3'd6;
    localparam logic [2:0] WR_WAIT  = 3'd7;

    localparam int CNT_MAX = (RD_CYCLES > WE_CYCLES) ? RD_CYCLES : WE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);

    logic [2:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] sreg_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] buf_reg;
    logic              sreg_en_q_reg;
    logic              oe_q_reg;
    logic              we_q_reg;
    logic              oe_fall;
    logic              we_fall;

    // Strobe samples track continuously, so a strobe already low when bus
    // mode is entered (or still low when an access finishes) is no edge.
    assign oe_fall = bus.avr_sreg_en && oe_q_reg && !bus.avr_oe;
    assign we_fall = bus.avr_sreg_en && we_q_reg && !bus.avr_we;

    always_comb begin
        addr_next = addr_reg;
        case (bus.avr_ctrl)
            2'b01:   addr_next = addr_reg + ADDR_W'(1);
            2'b10:   addr_next = addr_reg - ADDR_W'(1);
            default: addr_next = addr_reg;
        endcase
    end

    always_ff @(posedge avr_clk or negedge avr_reset) begin
        if (!avr_reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            sreg_reg      <= '0;
            addr_reg      <= '0;
            buf_reg       <= '0;
            sreg_en_q_reg <= 1'b0;
            oe_q_reg      <= 1'b0;
            we_q_reg      <= 1'b0;
        end else begin
            sreg_en_q_reg <= bus.avr_sreg_en;
            oe_q_reg      <= bus.avr_oe;
            we_q_reg      <= bus.avr_we;

            if (!bus.avr_sreg_en && state_reg == IDLE)
                sreg_reg <= {sreg_reg[ADDR_W-2:0], bus.avr_si};

            if (bus.avr_sreg_en && !sreg_en_q_reg)
                addr_reg <= sreg_reg;

            case (state_reg)
                IDLE: begin
                    // Write wins when both strobes fall together.
                    if (we_fall) begin
                        buf_reg   <= avr_data;
                        state_reg <= WR_SETUP;
                    end else if (oe_fall) begin
                        state_reg <= RD_SETUP;
                    end
                end
                RD_SETUP: begin
                    cnt_reg   <= '0;
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (cnt_reg == RD_LAST) begin
                        buf_reg   <= sram_data;
                        state_reg <= RD_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RD_HOLD: begin
                    if (bus.avr_oe) begin
                        addr_reg  <= addr_next;
                        state_reg <= IDLE;
                    end
                end
                WR_SETUP: begin
                    cnt_reg   <= '0;
                    state_reg <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (cnt_reg == WE_LAST)
                        state_reg <= WR_DONE;
                    else
                        cnt_reg <= cnt_reg + CNT_W'(1);
                end
                WR_DONE: begin
                    state_reg <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (bus.avr_we) begin
                        addr_reg  <= addr_next;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Strobes and bus drivers decode straight from the state register so an
    // asynchronous reset releases everything immediately.
    logic rd_active;
    logic wr_drive;
    assign rd_active = (state_reg == RD_SETUP) || (state_reg == RD_WAIT) ||
                       (state_reg == RD_HOLD);
    assign wr_drive  = (state_reg == WR_SETUP) || (state_reg == WR_PULSE) ||
                       (state_reg == WR_DONE);

    assign bus.sram_addr = addr_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.sram_oe_n = !rd_active;
    assign bus.sram_ce_n = !(rd_active || wr_drive);
    assign bus.sram_we_n = (state_reg != WR_PULSE);

    assign avr_data  = (state_reg == RD_HOLD) ? buf_reg : {DATA_W{1'bz}};
    assign sram_data = wr_drive ? buf_reg : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: directed self-checking bench for sram_bridge. Weak pullups
// make a released data bus read as all ones.
module tb_sram_bridge;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;
    localparam logic [DATA_W-1:0] REL = 8'hFF;

    logic clk;
    logic rst_n;
    logic              tb_avr_en;
    logic [DATA_W-1:0] tb_avr_val;
    logic              tb_sram_en;
    logic [DATA_W-1:0] tb_sram_val;
    wire  [DATA_W-1:0] avr_data;
    wire  [DATA_W-1:0] sram_data;

    int checks;
    int failures;

    sram_bridge_if #(.ADDR_W(ADDR_W)) bus_if ();

    sram_bridge #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYCLES(1), .WE_CYCLES(2)
    ) dut (
        .avr_clk  (clk),
        .avr_reset(rst_n),
        .bus      (bus_if),
        .avr_data (avr_data),
        .sram_data(sram_data)
    );

    assign avr_data  = tb_avr_en  ? tb_avr_val  : {DATA_W{1'bz}};
    assign sram_data = tb_sram_en ? tb_sram_val : {DATA_W{1'bz}};

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pull
        pullup (avr_data[gi]);
        pullup (sram_data[gi]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_addr(input logic [ADDR_W-1:0] v);
        bus_if.avr_sreg_en = 1'b0;
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            bus_if.avr_si = v[i];
            tick();
        end
        bus_if.avr_sreg_en = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (bus_if.sram_addr !== '0 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state addr=%h busy=%b required addr=0 busy=0", bus_if.sram_addr, bus_if.busy);
        end
        checks++;
        if ({bus_if.sram_oe_n, bus_if.sram_we_n, bus_if.sram_ce_n} !== 3'b111 || avr_data !== REL || sram_data !== REL) begin
            failures++;
            $display("FAIL reset_bus strobes=%b avr=%h sram=%h required 111/%h/%h",
                     {bus_if.sram_oe_n, bus_if.sram_we_n, bus_if.sram_ce_n}, avr_data, sram_data, REL, REL);
        end
        rst_n = 1'b1;
        bus_if.avr_sreg_en = 1'b1;
        tick(); tick();
        bus_if.avr_we = 1'b0; tb_avr_en = 1'b1; tb_avr_val = 8'h5A;
        tick();
        tb_avr_en = 1'b0;
        tick();
        checks++;
        if (bus_if.sram_we_n !== 1'b0 || sram_data !== 8'h5A) begin
            failures++;
            $display("FAIL reset_pre_pulse we_n=%b sram=%h required 0/5a", bus_if.sram_we_n, sram_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.sram_oe_n, bus_if.sram_we_n, bus_if.sram_ce_n} !== 3'b111 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_write strobes=%b busy=%b required 111/0",
                     {bus_if.sram_oe_n, bus_if.sram_we_n, bus_if.sram_ce_n}, bus_if.busy);
        end
        checks++;
        if (avr_data !== REL || sram_data !== REL || bus_if.sram_addr !== '0) begin
            failures++;
            $display("FAIL reset_mid_release avr=%h sram=%h addr=%h required %h/%h/0",
                     avr_data, sram_data, bus_if.sram_addr, REL, REL);
        end
        bus_if.avr_we = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        $display("reset mid-write: addr=%h busy=%b", bus_if.sram_addr, bus_if.busy);
    endtask

    task automatic test_shift();
        bus_if.avr_we = 1'b0;   // ignored while shifting, still low on entry
        shift_addr(21'h12345);
        checks++;
        if (bus_if.sram_addr !== 21'h12345) begin
            failures++;
            $display("FAIL shift_load addr=%h required 12345", bus_if.sram_addr);
        end
        for (int i = 0; i < 4; i++) begin
            bus_if.avr_si = ~bus_if.avr_si;
            tick();
        end
        checks++;
        if (bus_if.sram_addr !== 21'h12345 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL shift_hold addr=%h busy=%b required 12345/0", bus_if.sram_addr, bus_if.busy);
        end
        bus_if.avr_we = 1'b1;
        tick();
        $display("shift load: addr=%h", bus_if.sram_addr);
    endtask

    task automatic test_read();
        bus_if.avr_ctrl = 2'b00;
        tb_sram_en = 1'b1; tb_sram_val = 8'hAA;
        bus_if.avr_oe = 1'b0;
        tick();                                     // N+1
        checks++;
        if (bus_if.sram_oe_n !== 1'b0 || bus_if.sram_ce_n !== 1'b0 || bus_if.busy !== 1'b1) begin
            failures++;
            $display("FAIL read_setup oe_n=%b ce_n=%b busy=%b required 0/0/1",
                     bus_if.sram_oe_n, bus_if.sram_ce_n, bus_if.busy);
        end
        tick();                                     // N+2
        checks++;
        if (avr_data !== REL) begin
            failures++;
            $display("FAIL read_early avr=%h required released %h", avr_data, REL);
        end
        tick();                                     // N+3
        tb_sram_en = 1'b0;
        checks++;
        if (avr_data !== 8'hAA || bus_if.sram_oe_n !== 1'b0) begin
            failures++;
            $display("FAIL read_hold avr=%h oe_n=%b required aa/0", avr_data, bus_if.sram_oe_n);
        end
        bus_if.avr_oe = 1'b1;
        tick();
        checks++;
        if (avr_data !== REL || bus_if.sram_oe_n !== 1'b1 || bus_if.sram_ce_n !== 1'b1 ||
            bus_if.busy !== 1'b0 || bus_if.sram_addr !== 21'h12345) begin
            failures++;
            $display("FAIL read_end avr=%h oe_n=%b ce_n=%b busy=%b addr=%h required %h/1/1/0/12345",
                     avr_data, bus_if.sram_oe_n, bus_if.sram_ce_n, bus_if.busy, bus_if.sram_addr, REL);
        end
        $display("read: addr=12345 data=aa");
    endtask

    task automatic test_write();
        int we_low;
        bus_if.avr_ctrl = 2'b01;
        tb_avr_en = 1'b1; tb_avr_val = 8'hEE;
        bus_if.avr_we = 1'b0;
        tick();                                     // N+1
        tb_avr_val = 8'h11;                         // late change must not be captured
        checks++;
        if (sram_data !== 8'hEE || bus_if.sram_ce_n !== 1'b0 || bus_if.sram_we_n !== 1'b1) begin
            failures++;
            $display("FAIL write_setup sram=%h ce_n=%b we_n=%b required ee/0/1",
                     sram_data, bus_if.sram_ce_n, bus_if.sram_we_n);
        end
        tb_avr_en = 1'b0;
        we_low = 0;
        for (int i = 0; i < 3; i++) begin           // N+2..N+4
            tick();
            if (bus_if.sram_we_n === 1'b0) we_low++;
        end
        checks++;
        if (we_low != 2) begin
            failures++;
            $display("FAIL write_pulse_len we_low=%0d required 2", we_low);
        end
        checks++;
        if (bus_if.sram_we_n !== 1'b1 || sram_data !== 8'hEE || bus_if.sram_ce_n !== 1'b0) begin
            failures++;
            $display("FAIL write_done we_n=%b sram=%h ce_n=%b required 1/ee/0",
                     bus_if.sram_we_n, sram_data, bus_if.sram_ce_n);
        end
        tick();                                     // WR_WAIT
        checks++;
        if (sram_data !== REL || bus_if.sram_ce_n !== 1'b1 || bus_if.busy !== 1'b1 ||
            bus_if.sram_addr !== 21'h12345) begin
            failures++;
            $display("FAIL write_wait sram=%h ce_n=%b busy=%b addr=%h required %h/1/1/12345",
                     sram_data, bus_if.sram_ce_n, bus_if.busy, bus_if.sram_addr, REL);
        end
        bus_if.avr_we = 1'b1;
        tick();
        checks++;
        if (bus_if.sram_addr !== 21'h12346 || bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL write_incr addr=%h busy=%b required 12346/0", bus_if.sram_addr, bus_if.busy);
        end
        $display("write: addr=12345 data=ee next=%h", bus_if.sram_addr);
    endtask

    task automatic burst_read(input logic [ADDR_W-1:0] exp_addr, input logic [DATA_W-1:0] val);
        tb_sram_en = 1'b1; tb_sram_val = val;
        bus_if.avr_oe = 1'b0;
        tick();
        checks++;
        if (bus_if.sram_addr !== exp_addr || bus_if.sram_oe_n !== 1'b0) begin
            failures++;
            $display("FAIL burst_addr addr=%h oe_n=%b required %h/0", bus_if.sram_addr, bus_if.sram_oe_n, exp_addr);
        end
        tick(); tick();
        tb_sram_en = 1'b0;
        checks++;
        if (avr_data !== val) begin
            failures++;
            $display("FAIL burst_data avr=%h required %h", avr_data, val);
        end
        bus_if.avr_oe = 1'b1;
        tick();
        $display("burst read: addr=%h data=%h", exp_addr, val);
    endtask

    task automatic test_burst();
        shift_addr(21'h1FFFFE);
        bus_if.avr_ctrl = 2'b01;
        burst_read(21'h1FFFFE, 8'h01);
        burst_read(21'h1FFFFF, 8'h02);
        burst_read(21'h000000, 8'h03);
        checks++;
        if (bus_if.sram_addr !== 21'h000001) begin
            failures++;
            $display("FAIL burst_final addr=%h required 000001", bus_if.sram_addr);
        end
        shift_addr(21'h000000);
        bus_if.avr_ctrl = 2'b10;
        tb_avr_en = 1'b1; tb_avr_val = 8'h77;
        bus_if.avr_we = 1'b0;
        tick();
        tb_avr_en = 1'b0;
        repeat (4) tick();
        bus_if.avr_we = 1'b1;
        tick();
        checks++;
        if (bus_if.sram_addr !== 21'h1FFFFF) begin
            failures++;
            $display("FAIL burst_decr_wrap addr=%h required 1fffff", bus_if.sram_addr);
        end
        $display("burst write: addr=000000 data=77 next=%h", bus_if.sram_addr);
    endtask

    task automatic test_collision();
        int we_low;
        int oe_seen;
        int late_busy;
        bus_if.avr_ctrl = 2'b00;
        tb_avr_en = 1'b1; tb_avr_val = 8'h3C;
        bus_if.avr_oe = 1'b0;
        bus_if.avr_we = 1'b0;
        tick();
        tb_avr_en = 1'b0;
        checks++;
        if (sram_data !== 8'h3C || bus_if.sram_oe_n !== 1'b1) begin
            failures++;
            $display("FAIL collide_setup sram=%h oe_n=%b required 3c/1", sram_data, bus_if.sram_oe_n);
        end
        we_low = 0; oe_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_if.sram_we_n === 1'b0) we_low++;
            if (bus_if.sram_oe_n !== 1'b1) oe_seen++;
        end
        checks++;
        if (we_low != 2 || oe_seen != 0) begin
            failures++;
            $display("FAIL collide_seq we_low=%0d oe_low=%0d required 2/0", we_low, oe_seen);
        end
        bus_if.avr_we = 1'b1;
        tick();
        late_busy = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_if.busy !== 1'b0 || bus_if.sram_oe_n !== 1'b1) late_busy++;
        end
        checks++;
        if (late_busy != 0 || bus_if.sram_addr !== 21'h1FFFFF) begin
            failures++;
            $display("FAIL collide_no_retrigger active_cycles=%0d addr=%h required 0/1fffff",
                     late_busy, bus_if.sram_addr);
        end
        bus_if.avr_oe = 1'b1;
        tick();
        $display("collision: write only, data=3c");
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        tb_avr_en = 1'b0; tb_avr_val = '0;
        tb_sram_en = 1'b0; tb_sram_val = '0;
        bus_if.avr_si = 1'b0;
        bus_if.avr_sreg_en = 1'b0;
        bus_if.avr_ctrl = 2'b00;
        bus_if.avr_oe = 1'b1;
        bus_if.avr_we = 1'b1;

        test_reset();
        test_shift();
        test_read();
        test_write();
        test_burst();
        test_collision();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- Parametrised successor to the fixed 8-bit AVR/SRAM bus path.
- Loads an SRAM address serially from the AVR (MSB first), then arbitrates AVR read/write strobes into timed SRAM cycles.
- Optional post-increment/decrement of the address enables burst transfers without reloading.
- Sits between the AVR parallel port and the external SRAM in the CPLD top level.

Parameters:
- ADDR_W, 21, SRAM address width and shift-register length.
- DATA_W, 8, data bus width on both sides.
- RD_CYCLES, 1, SRAM read wait cycles before data capture (≥1).
- WE_CYCLES, 2, sram_we_n low-pulse length in cycles (≥1).

Ports:
- avr_clk  in  1  system clock; all logic on rising edge.
- avr_reset  in  1  asynchronous, active-low reset.
- avr_si  in  1  serial address bit, MSB first.
- avr_sreg_en  in  1  0 = shift mode, 1 = bus mode.
- avr_ctrl  in  2  address mode: 00 hold, 01 post-increment, 10 post-decrement, 11 hold.
- avr_oe  in  1  active-low AVR read strobe.
- avr_we  in  1  active-low AVR write strobe.
- avr_data  inout  DATA_W  AVR data bus.
- sram_data  inout  DATA_W  SRAM data bus.
- sram_addr  out  ADDR_W  SRAM address.
- sram_oe_n  out  1  SRAM output enable.
- sram_we_n  out  1  SRAM write enable.
- sram_ce_n  out  1  SRAM chip enable.
- busy  out  1  access in progress.

Behaviour:
- Reset (avr_reset=0, async), all held until release:
  - shift reg=0, sram_addr=0, data buffer=0.
  - sram_oe_n/we_n/ce_n=1, busy=0, state=IDLE.
  - avr_data and sram_data tri-stated.
- Reset mid-access: all strobes deassert and buses release immediately; the address does not advance.
- Shift mode (avr_sreg_en=0 and state IDLE):
  - Each clock: sreg <= {sreg[ADDR_W-2:0], avr_si}.
  - AVR strobes are ignored.
- Address load: the cycle after avr_sreg_en is sampled 0→1, sram_addr <= sreg. In bus mode sreg holds.
- avr_sreg_en falling during an access: the access completes normally; shifting resumes only in IDLE.
- Strobe detection (bus mode, IDLE only): edge = previous sample 1, current 0.
  - Both strobes fall in the same cycle: write wins.
  - A strobe already low on entry to bus mode is not an edge.
- Read sequence (avr_oe edge sampled in cycle N):
  - RD_SETUP (N+1): sram_ce_n=0, sram_oe_n=0, busy=1.
  - RD_WAIT: RD_CYCLES cycles; on the last, buffer <= sram_data.
  - RD_HOLD: from cycle N+2+RD_CYCLES, avr_data driven with buffer; SRAM strobes stay asserted.
  - avr_oe sampled 1: release avr_data, sram_oe_n=sram_ce_n=1, apply address mode, go to IDLE.
- Write sequence (avr_we edge sampled in cycle N):
  - Cycle N: buffer <= avr_data.
  - WR_SETUP (N+1): sram_ce_n=0, sram_data driven with buffer, busy=1.
  - WR_PULSE: sram_we_n=0 for WE_CYCLES cycles.
  - WR_DONE: sram_we_n=1 with data held for 1 cycle, then release sram_data and sram_ce_n=1.
  - WR_WAIT: wait for avr_we sampled 1, apply address mode, go to IDLE.
- Bus ownership: the block never drives both buses in the same cycle.
  - sram_data is driven only in WR_SETUP through WR_DONE.
  - avr_data is driven only in RD_HOLD.
- Address arithmetic: modulo 2^ADDR_W.
  - All-ones + 1 wraps to 0; 0 − 1 wraps to all-ones.
  - avr_ctrl is sampled at access completion.
- busy=1 in every state except IDLE.

Test Plan:
- Reset during WR_PULSE → all SRAM strobes=1 immediately, both buses Z, busy=0, sram_addr unchanged at 0.
- Shift 21 bits of 0x12345, raise sreg_en → sram_addr=0x12345 one cycle later; further avr_si toggling leaves it unchanged.
- Read: SRAM drives 0xAA, avr_oe low at cycle N (RD_CYCLES=1) → sram_oe_n/ce_n=0 at N+1, avr_data=0xAA from N+3; avr_oe high → avr_data Z and sram_oe_n=1 next cycle.
- Write 0xEE with avr_ctrl=01 → sram_data=0xEE from N+1, sram_we_n low exactly 2 cycles (N+2..N+3), address 0x12345→0x12346 after avr_we rises.
- Burst with avr_ctrl=01 from 0x1FFFFE: three reads → addresses 0x1FFFFE, 0x1FFFFF, 0x000000. With avr_ctrl=10 from 0x000000: one write → address 0x1FFFFF.
- avr_oe and avr_we fall in the same cycle → write sequence only, sram_oe_n stays 1; afterwards a strobe held low in IDLE starts no access.
